// File: rtl/decode24_scan_pkg.sv
// Purpose: shared constants and types for the decode24_scan switch-to-LED decoder.
// Latency: n/a (package only).
// Backpressure: none; the LED outputs cannot stall.
// Contents: code/LED widths, all-off LED pattern, 12 MHz default timing, LED drive helper.
package decode24_scan_pkg;

    localparam int CODE_W = 2;
    localparam int LED_W  = 4;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [LED_W-1:0]  led_t;

    // LEDs are low-active, so "all off" is all ones.
    localparam led_t LED_ALL_OFF = 4'b1111;

    // 20 ms debounce and 0.5 s scan step at 12 MHz.
    localparam int DEB_CYC_DEF  = 240000;
    localparam int SCAN_CYC_DEF = 6000000;

    // Low-active one-hot drive for a selected code.
    function automatic led_t led_drive(input code_t sel);
        return ~(led_t'(1) << sel);
    endfunction

endpackage

// File: rtl/decode24_scan_if.sv
// Purpose: pin-side bundle of the decoder: switch code, enable and mode in; LED drive out.
// Latency: n/a (wiring only).
// Backpressure: none; inputs are free-running pins, outputs are always accepted.
// Modports: master drives code/en/mode and observes led/code_out/valid; slave is the decoder.
interface decode24_scan_if;
    import decode24_scan_pkg::*;

    code_t code;
    logic  en;
    logic  mode;
    led_t  led;
    code_t code_out;
    logic  valid;

    modport master (output code, en, mode, input led, code_out, valid);
    modport slave  (input code, en, mode, output led, code_out, valid);

endinterface

// File: rtl/decode24_scan_debounce_sync.sv
// Purpose: 1-bit 2-flop synchroniser followed by a stable-count debouncer.
// Latency: 2 cycles sync + DEB_CYC cycles of stability (sync only without DECODE24_DEBOUNCE_EN).
// Backpressure: none.
// Ports: clk, rst_n (async active-low), din (async pin), dout (accepted level).
// Config: DECODE24_DEBOUNCE_EN compiles in the stable counter; otherwise dout is the synced bit.
module debounce_sync
    import decode24_scan_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic sync_1;
    logic sync_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
        end
    end

`ifdef DECODE24_DEBOUNCE_EN
    localparam int CNT_W = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;

    logic [CNT_W-1:0] stable_cnt;

    // The counter only runs while the synced bit disagrees with the accepted
    // level; any return to the accepted level restarts the stability window.
    // It clears on acceptance, so it never passes DEB_CYC-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= '0;
            dout       <= 1'b0;
        end else if (sync_2 == dout) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_W'(DEB_CYC - 1)) begin
            stable_cnt <= '0;
            dout       <= sync_2;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end
`else
    assign dout = sync_2;
`endif

endmodule

// File: rtl/decode24_scan.sv
// Purpose: registered 2-to-4 low-active LED decoder with debounced switches and auto-scan.
// Latency: 3 cycles en/mode pin to LED; manual code DEB_CYC+3 (3 without debounce).
// Backpressure: none; en low blanks the LEDs and freezes the scan.
// Ports: clk, rst_n (async active-low), bus (decode24_scan_if.slave: code/en/mode in, led/code_out/valid out).
// Config: DECODE24_DEBOUNCE_EN enables the per-bit switch debounce inside debounce_sync.
module decode24_scan
    import decode24_scan_pkg::*;
#(
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int SCAN_CYC = SCAN_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decode24_scan_if.slave        bus
);

    localparam int SCAN_W = (SCAN_CYC > 2) ? $clog2(SCAN_CYC) : 1;

    code_t             deb_code;
    logic [1:0]        ctl_s1;
    logic [1:0]        ctl_s2;
    logic              en_s;
    logic              mode_s;
    logic              en_d;
    logic              en_rise;
    logic [SCAN_W-1:0] scan_cnt;
    logic [SCAN_W-1:0] scan_base;
    code_t             scan_code;
    code_t             sel;
    led_t              led_q;
    code_t             code_q;
    logic              valid_q;

    for (genvar i = 0; i < CODE_W; i++) begin : g_code_deb
        debounce_sync #(
            .DEB_CYC (DEB_CYC)
        ) u_debounce_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (bus.code[i]),
            .dout  (deb_code[i])
        );
    end

    // en and mode share one 2-flop synchroniser: bit 1 = en, bit 0 = mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_s1 <= '0;
            ctl_s2 <= '0;
            en_d   <= 1'b0;
        end else begin
            ctl_s1 <= {bus.en, bus.mode};
            ctl_s2 <= ctl_s1;
            en_d   <= en_s;
        end
    end

    assign en_s    = ctl_s2[1];
    assign mode_s  = ctl_s2[0];
    assign en_rise = en_s & ~en_d;

    // On re-enable the step interval starts over, as if the counter sat at 0
    // this cycle; while disabled both counter and code simply hold.
    always_comb begin
        scan_base = scan_cnt;
        if (en_rise) begin
            scan_base = '0;
        end
    end

    // In manual mode the scan code tracks the debounced code so entering auto
    // mode starts from the code already on the LEDs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            scan_code <= '0;
        end else if (!mode_s) begin
            scan_cnt  <= '0;
            scan_code <= deb_code;
        end else if (en_s) begin
            if (scan_base == SCAN_W'(SCAN_CYC - 1)) begin
                scan_cnt  <= '0;
                scan_code <= scan_code + 2'd1;
            end else begin
                scan_cnt  <= scan_base + 1'b1;
            end
        end
    end

    assign sel = mode_s ? scan_code : deb_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q   <= LED_ALL_OFF;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else if (en_s) begin
            led_q   <= led_drive(sel);
            code_q  <= sel;
            valid_q <= 1'b1;
        end else begin
            led_q   <= LED_ALL_OFF;
            valid_q <= 1'b0;
        end
    end

    assign bus.led      = led_q;
    assign bus.code_out = code_q;
    assign bus.valid    = valid_q;

endmodule

// File: tb/tb_decode24_scan.sv
module tb_decode24_scan;

    localparam int DEB_CYC  = 4;
    localparam int SCAN_CYC = 8;
`ifdef DECODE24_DEBOUNCE_EN
    localparam int MLAT = DEB_CYC + 3;
`else
    localparam int MLAT = 3;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] led;
        logic [1:0] code;
        logic       valid;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    decode24_scan_if bus_if ();

    decode24_scan #(
        .DEB_CYC  (DEB_CYC),
        .SCAN_CYC (SCAN_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %b want %b (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic push_exp(input int c, input logic [3:0] l, input logic [1:0] cd,
                            input logic v, input string tag);
        exp_t e;
        e.cyc = c; e.led = l; e.code = cd; e.valid = v; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        check("drain_left", 8'(sb_q.size()), 8'd0);
        sb_q.delete();
    endtask

    // Scoreboard: compare every expectation due at the current cycle, flag any overdue.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                check({sb_q[i].tag, "_led"},   8'(bus_if.led),      8'(sb_q[i].led));
                check({sb_q[i].tag, "_code"},  8'(bus_if.code_out), 8'(sb_q[i].code));
                check({sb_q[i].tag, "_valid"}, 8'(bus_if.valid),    8'(sb_q[i].valid));
                sb_q.delete(i);
            end else if (sb_q[i].cyc < cyc) begin
                check({sb_q[i].tag, "_missed"}, 8'd1, 8'd0);
                sb_q.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        rst_n = 1'b0;
        bus_if.code = 2'b10;
        bus_if.en   = 1'b1;
        bus_if.mode = 1'b0;
        tick(3);
        check("rst_led",   8'(bus_if.led),      8'b0000_1111);
        check("rst_code",  8'(bus_if.code_out), 8'd0);
        check("rst_valid", 8'(bus_if.valid),    8'd0);

        // Release with code 10 held.
        rst_n = 1'b1;
        c = cyc;
        push_exp(c + 2, 4'b1111, 2'b00, 1'b0, "rel_idle");
`ifdef DECODE24_DEBOUNCE_EN
        push_exp(c + 3, 4'b1110, 2'b00, 1'b1, "rel_en");
        push_exp(c + MLAT - 1, 4'b1110, 2'b00, 1'b1, "rel_pre");
`endif
        push_exp(c + MLAT, 4'b1011, 2'b10, 1'b1, "man_10");
        drain();

        // Manual change to 01: exact latency.
        bus_if.code = 2'b01;
        c = cyc;
        push_exp(c + MLAT - 1, 4'b1011, 2'b10, 1'b1, "m01_pre");
        push_exp(c + MLAT,     4'b1101, 2'b01, 1'b1, "m01");
        drain();

        bus_if.code = 2'b00;
        c = cyc;
        push_exp(c + MLAT, 4'b1110, 2'b00, 1'b1, "m00");
        drain();

`ifdef DECODE24_DEBOUNCE_EN
        // Three-cycle glitch to 11 must never reach the LEDs.
        c = cyc;
        for (int k = 0; k <= 3 + MLAT + 2; k++) begin
            push_exp(c + k, 4'b1110, 2'b00, 1'b1, "glitch");
        end
        bus_if.code = 2'b11;
        tick(3);
        bus_if.code = 2'b00;
        drain();
`endif

        // Auto-scan from debounced 11: 0111 -> 1110 -> 1101 -> 1011 every 8 cycles.
        bus_if.code = 2'b11;
        c = cyc;
        push_exp(c + MLAT, 4'b0111, 2'b11, 1'b1, "m11");
        drain();
        bus_if.mode = 1'b1;
        c = cyc;
        push_exp(c + 3,  4'b0111, 2'b11, 1'b1, "auto_start");
        push_exp(c + 10, 4'b0111, 2'b11, 1'b1, "auto_hold3");
        push_exp(c + 11, 4'b1110, 2'b00, 1'b1, "auto_wrap0");
        push_exp(c + 18, 4'b1110, 2'b00, 1'b1, "auto_hold0");
        push_exp(c + 19, 4'b1101, 2'b01, 1'b1, "auto_1");
        push_exp(c + 26, 4'b1101, 2'b01, 1'b1, "auto_hold1");
        push_exp(c + 27, 4'b1011, 2'b10, 1'b1, "auto_2");
        tick(30);

        // Disable mid-interval, then re-enable: same code, full interval to the next step.
        bus_if.en = 1'b0;
        c = cyc;
        push_exp(c + 2,  4'b1011, 2'b10, 1'b1, "en_off_pre");
        push_exp(c + 3,  4'b1111, 2'b10, 1'b0, "en_off");
        push_exp(c + 12, 4'b1111, 2'b10, 1'b0, "en_off_hold");
        tick(12);
        bus_if.en = 1'b1;
        c = cyc;
        push_exp(c + 2,  4'b1111, 2'b10, 1'b0, "en_on_pre");
        push_exp(c + 3,  4'b1011, 2'b10, 1'b1, "en_on");
        push_exp(c + 10, 4'b1011, 2'b10, 1'b1, "en_on_hold");
        push_exp(c + 11, 4'b0111, 2'b11, 1'b1, "en_step");
        drain();

        // Asynchronous reset during auto mode.
        rst_n = 1'b0;
        #1;
        check("mid_rst_led",   8'(bus_if.led),      8'b0000_1111);
        check("mid_rst_code",  8'(bus_if.code_out), 8'd0);
        check("mid_rst_valid", 8'(bus_if.valid),    8'd0);
        tick(2);
        rst_n = 1'b1;
        c = cyc;
        push_exp(c + 2,  4'b1111, 2'b00, 1'b0, "post_rst_idle");
        push_exp(c + 3,  4'b1110, 2'b00, 1'b1, "post_rst_scan0");
        push_exp(c + 10, 4'b1110, 2'b00, 1'b1, "post_rst_hold");
        push_exp(c + 11, 4'b1101, 2'b01, 1'b1, "post_rst_scan1");
        tick(12);

        // Back to manual: debounced 11 returns once mode_s falls.
        bus_if.mode = 1'b0;
        c = cyc;
        push_exp(c + 2, 4'b1101, 2'b01, 1'b1, "manual_pre");
        push_exp(c + 3, 4'b0111, 2'b11, 1'b1, "manual_back");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
